// File: rtl/regfile_pkg.sv
// Shared constants and the bypass-match helper for the dual-write register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned X0_IDX       = 0;
    // Widest address the helper accepts; callers zero-extend to this width.
    localparam int unsigned AW_MAX       = 16;

    // A same-cycle write to the read address: drives both the read bypass and the BUSY override.
    function automatic logic wr_hit(input logic we,
                                    input logic [AW_MAX-1:0] wa,
                                    input logic [AW_MAX-1:0] ra);
        return we && (wa == ra);
    endfunction

endpackage

// File: rtl/regfile_2w2r_sb_if.sv
// Write, read and scoreboard-set bundle between the datapath and the register file.
interface regfile_2w2r_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT
);
    localparam int unsigned AW = $clog2(NREG);

    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            we4;
    logic [AW-1:0]   a4;
    logic [XLEN-1:0] wd4;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            sbset;
    logic [AW-1:0]   sba;
    logic            busy1;
    logic            busy2;

    modport master (
        output we3, a3, wd3, we4, a4, wd4, a1, a2, sbset, sba,
        input  rd1, rd2, busy1, busy2
    );

    modport slave (
        input  we3, a3, wd3, we4, a4, wd4, a1, a2, sbset, sba,
        output rd1, rd2, busy1, busy2
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: writebacks clear, producer issue sets, set wins on a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG    = NREG_DEFAULT,
    parameter bit          ZERO_X0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr3_en,
    input  logic [$clog2(NREG)-1:0] clr3_addr,
    input  logic                    clr4_en,
    input  logic [$clog2(NREG)-1:0] clr4_addr,
    input  logic                    set_en,
    input  logic [$clog2(NREG)-1:0] set_addr,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic                    busy1,
    output logic                    busy2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        pending_nxt = pending;
        for (int unsigned i = 0; i < NREG; i++) begin
            if ((clr3_en && clr3_addr == AW'(i)) || (clr4_en && clr4_addr == AW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            // A newly issued producer supersedes the one writing back this cycle.
            if (set_en && set_addr == AW'(i)) begin
                pending_nxt[i] = 1'b1;
            end
        end
        if (ZERO_X0) begin
            pending_nxt[X0_IDX] = 1'b0;
        end
    end

    function automatic logic fwd_hit(input logic [AW-1:0] ra);
        return wr_hit(clr3_en, AW_MAX'(clr3_addr), AW_MAX'(ra))
            || wr_hit(clr4_en, AW_MAX'(clr4_addr), AW_MAX'(ra));
    endfunction

    // Data already forwarded on the read port means decode need not stall.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!rst) begin
            busy1 = pending[ra1] && !(BYPASS && fwd_hit(ra1));
            busy2 = pending[ra2] && !(BYPASS && fwd_hit(ra2));
        end
    end

endmodule

// File: rtl/regfile_2w2r_sb.sv
// RISC-V integer register file: two write ports, two combinational read ports with bypass, pending scoreboard.
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned NREG    = NREG_DEFAULT,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_X0 = 1'b1
) (
    input logic               clk,
    input logic               rst,
    regfile_2w2r_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;

    // Port 4 has priority on an address collision; x0 is never stored when hardwired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (!(ZERO_X0 && i == X0_IDX)) begin
                    if (bus.we4 && bus.a4 == AW'(i)) begin
                        mem[i] <= bus.wd4;
                    end else if (bus.we3 && bus.a3 == AW'(i)) begin
                        mem[i] <= bus.wd3;
                    end
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_sel(input logic [AW-1:0] ra);
        logic [XLEN-1:0] val;
        val = mem[ra];
        if (BYPASS) begin
            if (wr_hit(bus.we4, AW_MAX'(bus.a4), AW_MAX'(ra))) begin
                val = bus.wd4;
            end else if (wr_hit(bus.we3, AW_MAX'(bus.a3), AW_MAX'(ra))) begin
                val = bus.wd3;
            end
        end
        if (ZERO_X0 && ra == AW'(X0_IDX)) begin
            val = '0;
        end
        return val;
    endfunction

    // Reads force zero during reset so a pending write cannot leak through the bypass.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!rst) begin
            rd1 = rd_sel(bus.a1);
            rd2 = rd_sel(bus.a2);
        end
    end

    regfile_scoreboard #(
        .NREG    (NREG),
        .ZERO_X0 (ZERO_X0),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .clr3_en   (bus.we3),
        .clr3_addr (bus.a3),
        .clr4_en   (bus.we4),
        .clr4_addr (bus.a4),
        .set_en    (bus.sbset),
        .set_addr  (bus.sba),
        .ra1       (bus.a1),
        .ra2       (bus.a2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    assign bus.rd1   = rd1;
    assign bus.rd2   = rd2;
    assign bus.busy1 = busy1;
    assign bus.busy2 = busy2;

endmodule
